// File: rtl/conv_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : conv_wb_arbiter
//  Purpose  : Arbitrates the shared vector-memory write port between the
//             convolution result stream (through a 4-entry FIFO) and the
//             memory-stage vector store. Conv results are written to
//             consecutive addresses starting at cfg_base for cfg_limit results.
//  Options  : CONV_WB_AGING_EN - when defined, a conv entry that has been
//             starved by 8 consecutive memory wins is given the next slot.
//  Revision : 1.0 - initial release
// ============================================================================
module conv_wb_arbiter (
  input  logic         clk,
  input  logic         reset,       // asynchronous, active-low
  input  logic         cfg_start,
  input  logic [15:0]  cfg_base,
  input  logic [15:0]  cfg_limit,
  input  logic         conv_write,
  input  logic [127:0] conv_v,
  output logic         conv_full,
  input  logic         mem_req,
  input  logic [15:0]  mem_addr,
  input  logic [127:0] mem_data,
  output logic         mem_gnt,
  output logic         wr_en,
  output logic [15:0]  wr_addr,
  output logic [127:0] wr_data,
  output logic         busy,
  output logic         done,
  output logic         overflow
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [2:0] C_FIFO_DEPTH = 3'd4;

  // Registered state
  logic [1:0]   state_q,     state_d;
  logic [2:0]   count_q,     count_d;
  logic [1:0]   rd_ptr_q,    rd_ptr_d;
  logic [1:0]   wr_ptr_q,    wr_ptr_d;
  logic [15:0]  base_q,      base_d;
  logic [15:0]  limit_q,     limit_d;
  logic [15:0]  acc_q,       acc_d;       // results accepted into the FIFO
  logic [15:0]  idx_q,       idx_d;       // results written to memory
  logic         overflow_q,  overflow_d;
  logic         conv_full_q, conv_full_d;
  logic         wr_en_q,     wr_en_d;
  logic [15:0]  wr_addr_q,   wr_addr_d;
  logic [127:0] wr_data_q,   wr_data_d;

  logic [127:0] fifo_q [0:3];

  // Arbitration wires
  logic w_age_trig;
  logic w_force_conv;
  logic w_mem_win;
  logic w_pop;
  logic w_push;

`ifdef CONV_WB_AGING_EN
  logic [3:0] age_q, age_d;

  assign w_age_trig = (age_q == 4'd8);

  // Count consecutive memory wins that leave a conv entry waiting
  always_comb begin
    age_d = age_q;
    if (cfg_start || (count_q == 3'd0) || w_pop) begin
      age_d = 4'd0;
    end else if (w_mem_win) begin
      age_d = age_q + 4'd1;
    end
  end

  // Aging counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      age_q <= 4'd0;
    end else begin
      age_q <= age_d;
    end
  end
`else
  assign w_age_trig = 1'b0;
`endif

  // A full FIFO (or a starved entry) takes the port regardless of mem_req.
  // Pops use count_q, so an entry is never popped in its own push cycle.
  assign w_force_conv = (count_q == C_FIFO_DEPTH) || w_age_trig;
  assign w_mem_win    = mem_req && !w_force_conv;
  assign w_pop        = (count_q != 3'd0) && !w_mem_win && !cfg_start;
  assign w_push       = conv_write && (state_q == ST_RUN) && !conv_full_q && !cfg_start;

  // Next-state: FIFO bookkeeping, write-port mux, job FSM and restart
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    base_d     = base_q;
    limit_d    = limit_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    overflow_d = overflow_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (w_pop) begin
      wr_en_d   = 1'b1;
      wr_addr_d = base_q + idx_q;
      wr_data_d = fifo_q[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + 2'd1;
      idx_d     = idx_q + 16'd1;
    end else if (w_mem_win) begin
      wr_en_d   = 1'b1;
      wr_addr_d = mem_addr;
      wr_data_d = mem_data;
    end

    if (w_push) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
      acc_d    = acc_q + 16'd1;
    end

    unique case ({w_push, w_pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    if (conv_write && !w_push) begin
      overflow_d = 1'b1;
    end

    unique case (state_q)
      ST_RUN:   if (acc_d == limit_q) state_d = ST_DRAIN;
      ST_DRAIN: if (count_q == 3'd0)  state_d = ST_DONE;
      default:  state_d = state_q;
    endcase

    // Restart overrides everything except the already-selected write beat
    if (cfg_start) begin
      count_d    = 3'd0;
      rd_ptr_d   = 2'd0;
      wr_ptr_d   = 2'd0;
      acc_d      = 16'd0;
      idx_d      = 16'd0;
      base_d     = cfg_base;
      limit_d    = cfg_limit;
      overflow_d = 1'b0;
      state_d    = (cfg_limit == 16'd0) ? ST_DONE : ST_RUN;
    end

    conv_full_d = (count_d == C_FIFO_DEPTH);
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      count_q     <= 3'd0;
      rd_ptr_q    <= 2'd0;
      wr_ptr_q    <= 2'd0;
      base_q      <= 16'd0;
      limit_q     <= 16'd0;
      acc_q       <= 16'd0;
      idx_q       <= 16'd0;
      overflow_q  <= 1'b0;
      conv_full_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 16'd0;
      wr_data_q   <= 128'd0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      base_q      <= base_d;
      limit_q     <= limit_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      overflow_q  <= overflow_d;
      conv_full_q <= conv_full_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // FIFO storage; contents are only meaningful under count_q, so no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_q[wr_ptr_q] <= conv_v;
    end
  end

  assign conv_full = conv_full_q;
  assign mem_gnt   = w_mem_win && reset;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_wb_arbiter
//  Purpose  : Self-checking bench for conv_wb_arbiter: directed scenarios plus
//             randomized jobs compared against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv_wb_arbiter;

`ifdef CONV_WB_AGING_EN
  localparam bit AGING = 1'b1;
`else
  localparam bit AGING = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cfg_start = 1'b0;
  logic [15:0]  cfg_base = 16'd0;
  logic [15:0]  cfg_limit = 16'd0;
  logic         conv_write = 1'b0;
  logic [127:0] conv_v = 128'd0;
  logic         mem_req = 1'b0;
  logic [15:0]  mem_addr = 16'd0;
  logic [127:0] mem_data = 128'd0;
  logic         conv_full, mem_gnt, wr_en, busy, done, overflow;
  logic [15:0]  wr_addr;
  logic [127:0] wr_data;

  conv_wb_arbiter dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_base(cfg_base),
    .cfg_limit(cfg_limit), .conv_write(conv_write), .conv_v(conv_v),
    .conv_full(conv_full), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_gnt(mem_gnt), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: job phase 0=idle 1=run 2=drain 3=done, FIFO as a queue
  int           m_phase;
  logic [127:0] m_q [$];
  logic [15:0]  m_base, m_limit, m_acc, m_wrote;
  bit           m_ovf;
  int           m_age;
  logic         e_wr_en, e_full, e_gnt;
  logic [15:0]  e_wr_addr;
  logic [127:0] e_wr_data;

  logic [15:0]  wa [$];
  int           n_we;
  bit           fix_mem = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_q.delete();
    m_base = 16'd0; m_limit = 16'd0; m_acc = 16'd0; m_wrote = 16'd0;
    m_ovf = 1'b0; m_age = 0;
    e_wr_en = 1'b0; e_wr_addr = 16'd0; e_wr_data = 128'd0; e_full = 1'b0;
  endtask

  // One clock: check the combinational grant, advance the model, check registers
  task automatic step();
    bit forced, pop, push;
    int sz;
    @(negedge clk);
    sz     = m_q.size();
    forced = (sz == 4) || (AGING && m_age >= 8);
    e_gnt  = mem_req && !forced;
    chk("mem_gnt", mem_gnt, e_gnt);
    pop  = (sz > 0) && !cfg_start && !e_gnt;
    push = conv_write && (m_phase == 1) && (sz < 4) && !cfg_start;
    if (pop) begin
      e_wr_en = 1'b1; e_wr_addr = m_base + m_wrote; e_wr_data = m_q.pop_front();
      m_wrote = m_wrote + 16'd1;
    end else if (e_gnt) begin
      e_wr_en = 1'b1; e_wr_addr = mem_addr; e_wr_data = mem_data;
    end else begin
      e_wr_en = 1'b0;
    end
    if (cfg_start || sz == 0 || pop) m_age = 0;
    else if (e_gnt) m_age++;
    if (cfg_start) m_ovf = 1'b0;
    else if (conv_write && !push) m_ovf = 1'b1;
    if (push) begin m_q.push_back(conv_v); m_acc = m_acc + 16'd1; end
    if (cfg_start) begin
      m_q.delete(); m_acc = 16'd0; m_wrote = 16'd0;
      m_base = cfg_base; m_limit = cfg_limit;
      m_phase = (cfg_limit == 16'd0) ? 3 : 1;
    end else if (m_phase == 1 && m_acc == m_limit) m_phase = 2;
    else if (m_phase == 2 && sz == 0) m_phase = 3;
    e_full = (m_q.size() == 4);
    @(posedge clk); #1;
    chk("wr_en", wr_en, e_wr_en);
    chk("wr_addr", wr_addr, e_wr_addr);
    chk("wr_data", wr_data, e_wr_data);
    chk("conv_full", conv_full, e_full);
    chk("busy", busy, (m_phase == 1 || m_phase == 2));
    chk("done", done, (m_phase == 3));
    chk("overflow", overflow, m_ovf);
    if (wr_en === 1'b1) begin wa.push_back(wr_addr); n_we++; end
  endtask

  task automatic cyc(input bit cs, input bit cw, input bit mr);
    cfg_start  = cs;
    conv_write = cw;
    mem_req    = mr;
    conv_v     = {$urandom(), $urandom(), $urandom(), $urandom()};
    mem_addr   = fix_mem ? 16'hA000 : 16'($urandom());
    mem_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
    step();
    cfg_start  = 1'b0;
  endtask

  function automatic int hits(input logic [15:0] a);
    int h = 0;
    foreach (wa[i]) if (wa[i] == a) h++;
    return h;
  endfunction

  initial begin
    model_reset();
    // Reset state, with a pending mem_req that must not be granted
    mem_req = 1'b1;
    #1;
    chk("rst_mem_gnt", mem_gnt, 1'b0);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_wr_addr", wr_addr, 16'h0000);
    chk("rst_wr_data", wr_data, 128'd0);
    chk("rst_conv_full", conv_full, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    mem_req = 1'b0;
    #11 reset = 1'b1;

    // Three results at 0x0100, each written two cycles after its push
    cfg_base = 16'h0100; cfg_limit = 16'd3;
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    chk("r030_no_early_wr", wr_en, 1'b0);
    cyc(0, 1, 0);
    chk("r030_wr0", wr_addr, 16'h0100);
    cyc(0, 1, 0);
    chk("r030_wr1", wr_addr, 16'h0101);
    cyc(0, 0, 0);
    chk("r030_wr2", wr_addr, 16'h0102);
    repeat (3) cyc(0, 0, 0);
    chk("r030_done", done, 1'b1);

    // Memory holds the port until the FIFO fills, then conv takes one slot
    cfg_base = 16'h0200; cfg_limit = 16'd4;
    cyc(1, 0, 1);
    repeat (4) cyc(0, 1, 1);
    chk("r031_full_set", conv_full, 1'b1);
    cyc(0, 0, 1);
    chk("r031_conv_addr", wr_addr, 16'h0200);
    chk("r031_full_clr", conv_full, 1'b0);
    repeat (6) cyc(0, 0, 0);

    // Fifth push while full is dropped and flags overflow
    cfg_base = 16'h0400; cfg_limit = 16'd8;
    cyc(1, 0, 1);
    repeat (4) cyc(0, 1, 1);
    cyc(0, 1, 1);
    chk("r032_overflow", overflow, 1'b1);
    chk("r032_first_conv", wr_addr, 16'h0400);
    n_we = 0;
    repeat (8) cyc(0, 0, 0);
    chk("r032_remaining_writes", n_we, 3);
    chk("r032_sticky", overflow, 1'b1);

    // Address wrap
    cfg_base = 16'hFFFF; cfg_limit = 16'd2;
    cyc(1, 0, 0);
    wa.delete();
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    repeat (3) cyc(0, 0, 0);
    chk("r033_count", wa.size(), 2);
    if (wa.size() >= 2) begin
      chk("r033_addr0", wa[0], 16'hFFFF);
      chk("r033_addr1", wa[1], 16'h0000);
    end

    // Reset mid-DRAIN with two entries held back by memory traffic
    cfg_base = 16'h0500; cfg_limit = 16'd2;
    cyc(1, 0, 1);
    cyc(0, 1, 1);
    cyc(0, 1, 1);
    chk("r034_busy_before", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("r034_wr_en", wr_en, 1'b0);
    chk("r034_wr_addr", wr_addr, 16'h0000);
    chk("r034_wr_data", wr_data, 128'd0);
    chk("r034_busy", busy, 1'b0);
    chk("r034_done", done, 1'b0);
    chk("r034_full", conv_full, 1'b0);
    chk("r034_mem_gnt", mem_gnt, 1'b0);
    model_reset();
    mem_req = 1'b0;
    #3 reset = 1'b1;
    n_we = 0;
    repeat (6) cyc(0, 0, 0);
    chk("r034_no_wr_after", n_we, 0);

    // One conv entry starved by held memory traffic
    fix_mem = 1'b1;
    cfg_base = 16'h0300; cfg_limit = 16'd1;
    cyc(1, 0, 1);
    wa.delete();
    cyc(0, 1, 1);
    repeat (12) cyc(0, 0, 1);
    chk("r035_conv_while_mem_held", hits(16'h0300), AGING ? 1 : 0);
    repeat (3) cyc(0, 0, 0);
    chk("r035_conv_total", hits(16'h0300), 1);
    fix_mem = 1'b0;

    // Randomized jobs
    for (int j = 0; j < 25; j++) begin
      int pw, pm;
      cfg_base  = (j % 5 == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7)) : 16'($urandom());
      cfg_limit = 16'($urandom_range(0, 10));
      pw = $urandom_range(20, 90);
      pm = $urandom_range(0, 80);
      cyc(1, $urandom_range(0, 1), $urandom_range(0, 1));
      for (int k = 0; k < 40; k++) begin
        cyc(0, $urandom_range(0, 99) < pw, $urandom_range(0, 99) < pm);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_wb_arbiter.md
CONV_WB_ARBITER -- requirements
Module: conv_wb_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low; asserted (0) forces reset state immediately.
REQ-003 SHALL have port: cfg_start  input  1  one-cycle pulse; loads base/limit, clears counters, enters RUN.
REQ-004 SHALL have port: cfg_base  input  16  vector-memory address of first conv result, sampled on cfg_start.
REQ-005 SHALL have port: cfg_limit  input  16  number of conv results in the job, sampled on cfg_start; 0 means go directly to DONE.
REQ-006 SHALL have port: conv_write  input  1  conv result valid.
REQ-007 SHALL have port: conv_v  input  128  16 lanes x INT8 conv result vector.
REQ-008 SHALL have port: conv_full  output  1  registered; FIFO holds 4 entries.
REQ-009 SHALL have port: mem_req / mem_addr / mem_data  input  1/16/128  memory-stage vector store request.
REQ-010 SHALL have port: mem_gnt  output  1  combinational grant to memory stage, same cycle as mem_req.
REQ-011 SHALL have port: wr_en / wr_addr / wr_data  output  1/16/128  registered shared vector-memory write port.
REQ-012 SHALL have port: busy / done / overflow  output  1 each  state flags; overflow sticky.

Function
REQ-013 SHALL implement FSM IDLE -> RUN (cfg_start) -> DRAIN (accepted count == limit) -> DONE (FIFO empty) -> RUN (cfg_start).
REQ-014 SHALL accept conv_write into a 4-entry FIFO only in RUN and only when conv_full==0; accepted count increments per push.
REQ-015 SHALL drop conv_write when FIFO full, in IDLE, DRAIN or DONE, and set overflow=1 (sticky until reset or cfg_start).
REQ-016 SHALL NOT accept a push while full even if a pop occurs the same cycle.
REQ-017 SHALL arbitrate each cycle: conv wins if FIFO count==4 (or aging trigger, REQ-028); else memory wins if mem_req; else conv wins if FIFO non-empty.
REQ-018 SHALL assert mem_gnt only when mem_req==1 and memory wins; a non-granted mem_req is held by requester, not queued.
REQ-019 SHALL register the winner onto wr_en/wr_addr/wr_data one cycle after grant (latency 1).
REQ-020 SHALL write conv entries to wr_addr = cfg_base + written index, 16-bit modulo wrap (0xFFFF + 1 -> 0x0000).
REQ-021 SHALL not pop an entry in its push cycle; earliest conv write: conv_write at cycle N, pop N+1, wr_en N+2.
REQ-022 SHALL hold busy=1 in RUN and DRAIN; done=1 in DONE only.
REQ-023 SHALL, on cfg_start in any state, flush FIFO, clear counters/overflow/done, enter RUN; a write registered that cycle still completes.
REQ-024 SHALL, with cfg_limit==0, go from cfg_start to DONE next cycle.

Reset
REQ-025 SHALL on reset==0: state IDLE, FIFO empty, counters 0, conv_full=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, overflow=0, mem_gnt=0.
REQ-026 SHALL abandon in-flight job on reset mid-RUN/DRAIN; no further wr_en until next cfg_start traffic.

Configuration
REQ-027 SHALL compile aging logic only when macro CONV_WB_AGING_EN is defined.
REQ-028 SHALL, with CONV_WB_AGING_EN, count consecutive cycles memory wins while FIFO non-empty; at 8 the next arbitration goes to conv and counter clears.
REQ-029 SHALL, without CONV_WB_AGING_EN, use strict priority per REQ-017 without aging.

Verification
REQ-030 SHALL cover: base=0x0100, limit=3, three conv_write, no mem_req -> wr_en at 0x0100/0x0101/0x0102, each 2 cycles after its push, then done=1.
REQ-031 SHALL cover: mem_req held high, 4 conv pushes -> mem_gnt until FIFO count==4, then conv write, conv_full=1 then 0.
REQ-032 SHALL cover: 5th conv_write while full -> dropped, overflow=1, only 4 conv writes issued.
REQ-033 SHALL cover: base=0xFFFF, limit=2 -> wr_addr 0xFFFF then 0x0000.
REQ-034 SHALL cover: reset low mid-DRAIN with 2 entries queued -> outputs at reset values immediately, no further wr_en.
REQ-035 SHALL cover (CONV_WB_AGING_EN): mem_req held, 1 conv entry -> conv written after 8 memory grants; without macro it waits for mem_req drop.
